control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle control FSM for the rv32i core. Fetches into the IR, reads i_opcode from the instruction
//  decoder, and drives every datapath enable and mux select (PC, ALU operands, regfile write, data memory).
//  One instruction in flight at a time; memory stalls and illegal opcodes handled here.
// PARAMETERS
//  TIMEOUT  16  max cycles req may wait for ack before FAULT (>=2; counter width $clog2(TIMEOUT+1))
// PORTS
//  clk             in   1  core clock
//  rst             in   1  synchronous reset, active-high
//  o_imem_req      out  1  instruction fetch request
//  i_imem_ack      in   1  fetch data valid this cycle
//  o_ir_load       out  1  capture instruction into IR (= o_imem_req & i_imem_ack)
//  i_opcode        in   7  opcode from instruction decoder (stable while IR held)
//  i_branch_taken  in   1  ALU compare result, sampled in EXECUTE
//  o_dmem_req      out  1  data memory request
//  o_dmem_we       out  1  1=store, 0=load; valid while o_dmem_req
//  i_dmem_ack      in   1  data access complete / load data valid
//  o_alu_a_sel     out  1  0=rs1, 1=PC
//  o_alu_b_sel     out  1  0=rs2, 1=immediate
//  o_pc_load       out  1  PC write enable
//  o_pc_sel        out  2  0=PC+4, 1=PC+imm, 2=rs1+imm (datapath clears bit0)
//  o_rd_we         out  1  register file write enable
//  o_rd_sel        out  2  0=ALU, 1=load data, 2=PC+4, 3=immediate
//  o_retire        out  1  one-cycle pulse per completed instruction
//  o_fault         out  1  sticky fault flag
//  o_state         out  3  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4 FAULT=7; registered state, combinational outputs.
//  Reset: while rst=1 all outputs 0, state<=FETCH, timer<=0, fault cleared. First req the cycle rst drops.
//  rst mid-instruction aborts it: no pc_load/rd_we/retire is emitted.
//  FETCH: imem_req=1 held until ack; on ack ir_load=1, ->DECODE. Acks while req=0 are ignored.
//  DECODE: 1 cycle. Legal = OpRInt,OpIInt,OpILoad,OpIJump,OpSBranch,OpSStore,OpUImm,OpUPc,OpUJump;
//    illegal ->FAULT, else ->EXECUTE.
//  Operand selects (EXECUTE..WRITEBACK): a_sel=1 for OpUPc,OpUJump,OpSBranch; b_sel=0 only for OpRInt.
//  EXECUTE: OpSBranch: pc_load=1, pc_sel=i_branch_taken?1:0, retire=1, ->FETCH.
//    OpILoad/OpSStore ->MEMORY; all others ->WRITEBACK.
//  MEMORY: dmem_req=1, dmem_we=(OpSStore); held until ack. On ack: store -> pc_load=1, pc_sel=0,
//    retire=1, ->FETCH; load ->WRITEBACK.
//  WRITEBACK: rd_we=1, pc_load=1, retire=1, ->FETCH. rd_sel: OpILoad=1, OpIJump/OpUJump=2, OpUImm=3, else 0.
//    pc_sel: OpUJump=1, OpIJump=2, else 0.
//  Latency (ack in first req cycle): branch 3, R/I/U/J/store 4, load 5 cycles; +1 per ack wait cycle.
//  Timer: cleared on entry to FETCH/MEMORY, +1 each req cycle without ack. Timer==TIMEOUT-1 without ack
//    -> FAULT next cycle (req high exactly TIMEOUT cycles). Ack on that last cycle wins (no fault).
//  FAULT: all reqs/enables 0, o_fault=1, absorbing until rst. No retire for the faulting instruction.
//  At most one of o_imem_req/o_dmem_req high in any cycle; pc_load and rd_we only in the retire cycle.
// TESTING
//  ADD (0110011), imem ack in 1st cycle -> retire at cycle 3 with rd_we=1, rd_sel=0, pc_sel=0, b_sel=0.
//  BEQ (1100011), branch_taken=1 -> retire cycle 2, pc_sel=1, a_sel=1, rd_we never 1; taken=0 -> pc_sel=0.
//  LW (0000011), dmem ack 3 cycles late -> dmem_req high 4 cycles, we=0; rd_we,rd_sel=1 next cycle; 8 total.
//  JALR (1100111) -> WRITEBACK rd_sel=2, pc_sel=2; JAL (1101111) -> rd_sel=2, pc_sel=1, a_sel=1.
//  TIMEOUT=16, no imem ack -> req high 16 cycles, then fault=1, state=7; ack at cycle 16 -> no fault.
//  Opcode 0000000 -> FAULT after DECODE, no retire/rd_we; rst pulse mid-MEMORY -> FETCH, fault=0, no retire.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM for the rv32i core: fetch, decode, execute, memory, writeback.
// One instruction in flight; handles memory ack stalls, request timeouts and illegal opcodes.
module control_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       o_imem_req,
    input  logic       i_imem_ack,
    output logic       o_ir_load,
    input  logic [6:0] i_opcode,
    input  logic       i_branch_taken,
    output logic       o_dmem_req,
    output logic       o_dmem_we,
    input  logic       i_dmem_ack,
    output logic       o_alu_a_sel,
    output logic       o_alu_b_sel,
    output logic       o_pc_load,
    output logic [1:0] o_pc_sel,
    output logic       o_rd_we,
    output logic [1:0] o_rd_sel,
    output logic       o_retire,
    output logic       o_fault,
    output logic [2:0] o_state
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd7;

    localparam logic [6:0] OP_R_INT    = 7'b0110011;
    localparam logic [6:0] OP_I_INT    = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_I_JUMP   = 7'b1100111;
    localparam logic [6:0] OP_S_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_S_STORE  = 7'b0100011;
    localparam logic [6:0] OP_U_IMM    = 7'b0110111;
    localparam logic [6:0] OP_U_PC     = 7'b0010111;
    localparam logic [6:0] OP_U_JUMP   = 7'b1101111;

    logic [2:0]    state, state_next;
    logic [TW-1:0] timer, timer_next;

    logic is_r, is_i, is_load, is_ijump, is_branch, is_store, is_uimm, is_upc, is_ujump;
    logic legal;

    assign is_r      = (i_opcode == OP_R_INT);
    assign is_i      = (i_opcode == OP_I_INT);
    assign is_load   = (i_opcode == OP_I_LOAD);
    assign is_ijump  = (i_opcode == OP_I_JUMP);
    assign is_branch = (i_opcode == OP_S_BRANCH);
    assign is_store  = (i_opcode == OP_S_STORE);
    assign is_uimm   = (i_opcode == OP_U_IMM);
    assign is_upc    = (i_opcode == OP_U_PC);
    assign is_ujump  = (i_opcode == OP_U_JUMP);
    assign legal     = is_r | is_i | is_load | is_ijump | is_branch | is_store |
                       is_uimm | is_upc | is_ujump;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Outputs decode from the current state; everything is forced low while rst is held.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        o_imem_req  = 1'b0;
        o_ir_load   = 1'b0;
        o_dmem_req  = 1'b0;
        o_dmem_we   = 1'b0;
        o_alu_a_sel = 1'b0;
        o_alu_b_sel = 1'b0;
        o_pc_load   = 1'b0;
        o_pc_sel    = 2'd0;
        o_rd_we     = 1'b0;
        o_rd_sel    = 2'd0;
        o_retire    = 1'b0;
        o_fault     = 1'b0;
        o_state     = 3'd0;
        if (!rst) begin
            o_state = state;
            if (state == S_EXECUTE || state == S_MEMORY || state == S_WRITEBACK) begin
                o_alu_a_sel = is_upc | is_ujump | is_branch;
                o_alu_b_sel = ~is_r;
            end
            case (state)
                S_FETCH: begin
                    o_imem_req = 1'b1;
                    if (i_imem_ack) begin
                        o_ir_load  = 1'b1;
                        state_next = S_DECODE;
                    end else if (timer == TIMER_LAST) begin
                        state_next = S_FAULT;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                S_DECODE: begin
                    state_next = legal ? S_EXECUTE : S_FAULT;
                end
                S_EXECUTE: begin
                    if (is_branch) begin
                        o_pc_load  = 1'b1;
                        o_pc_sel   = {1'b0, i_branch_taken};
                        o_retire   = 1'b1;
                        state_next = S_FETCH;
                        timer_next = '0;
                    end else if (is_load || is_store) begin
                        state_next = S_MEMORY;
                        timer_next = '0;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    o_dmem_req = 1'b1;
                    o_dmem_we  = is_store;
                    if (i_dmem_ack) begin
                        if (is_store) begin
                            o_pc_load  = 1'b1;
                            o_retire   = 1'b1;
                            state_next = S_FETCH;
                            timer_next = '0;
                        end else begin
                            state_next = S_WRITEBACK;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state_next = S_FAULT;
                    end else begin
                        timer_next = timer + TW'(1);
                    end
                end
                S_WRITEBACK: begin
                    o_rd_we    = 1'b1;
                    o_pc_load  = 1'b1;
                    o_retire   = 1'b1;
                    o_rd_sel   = is_load ? 2'd1 : (is_ijump | is_ujump) ? 2'd2 : is_uimm ? 2'd3 : 2'd0;
                    o_pc_sel   = is_ujump ? 2'd1 : is_ijump ? 2'd2 : 2'd0;
                    state_next = S_FETCH;
                    timer_next = '0;
                end
                S_FAULT: begin
                    o_fault = 1'b1;
                end
                default: begin
                    state_next = S_FAULT;
                end
            endcase
        end
    end

endmodule
